// File: rtl/intr_ctrl_pkg.sv
// Shared register-map constants for the memory-mapped interrupt controller.
// Offsets are word indices (mem_addr[4:2]) within the 32-byte window.
package intr_ctrl_pkg;

    localparam logic [2:0] INTR_PENDING = 3'd0;
    localparam logic [2:0] INTR_MASK    = 3'd1;
    localparam logic [2:0] INTR_CTRL    = 3'd2;
    localparam logic [2:0] INTR_CLAIM   = 3'd3;
    localparam logic [2:0] INTR_EDGE    = 3'd4;

    localparam int          ID_W        = 5;
    localparam logic [31:0] CLAIM_VALID = 32'h8000_0000;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous request line, plus a delay flop
// so a rising edge of the synchronised level can be detected.
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic s,
    output logic rise
);

    logic meta_reg;
    logic s_reg;
    logic s_d_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b0;
            s_reg    <= 1'b0;
            s_d_reg  <= 1'b0;
        end else begin
            meta_reg <= src;
            s_reg    <= meta_reg;
            s_d_reg  <= s_reg;
        end
    end

    assign s    = s_reg;
    assign rise = s_reg & ~s_d_reg;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: per-source sync/edge detect, pending/mask/edge state,
// claim-with-acknowledge read, and a registered level request to the core.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int          N_IRQ     = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic             mem_ren,
    input  logic             mem_wen,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_dout,
    output logic             sel,
    output logic [31:0]      rdata,
    output logic             ir_out
);

    logic [N_IRQ-1:0] pending_reg;
    logic [N_IRQ-1:0] pending_next;
    logic [N_IRQ-1:0] mask_reg;
    logic [N_IRQ-1:0] edge_reg;
    logic             gie_reg;
    logic             ir_reg;

    logic [N_IRQ-1:0] s;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] active;
    logic [2:0]       offset;
    logic             wr;
    logic             w1c;
    logic             any_active;
    logic             claim_take;
    logic [ID_W-1:0]  claim_id;

    // Lowest-numbered set bit wins.
    function automatic logic [ID_W-1:0] lowest_id(input logic [N_IRQ-1:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) id = ID_W'(i);
        end
        return id;
    endfunction

    assign sel        = (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign offset     = mem_addr[4:2];
    assign wr         = mem_wen & sel;
    assign w1c        = wr & (offset == INTR_PENDING);
    assign active     = pending_reg & mask_reg;
    assign any_active = |active;
    assign claim_id   = lowest_id(active);
    // A simultaneous write suppresses the acknowledge side effect of a claim read.
    assign claim_take = mem_ren & sel & (offset == INTR_CLAIM) & ~mem_wen & any_active;

    generate
        for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_src
            irq_sync_edge u_sync (
                .clk  (clk),
                .rst  (rst),
                .src  (irq_src[gi]),
                .s    (s[gi]),
                .rise (rise[gi])
            );

            // Edge sources: a new rise beats any clear in the same cycle.
            // Level sources simply track the synchronised input.
            assign pending_next[gi] = !edge_reg[gi] ? s[gi] :
                                      rise[gi]      ? 1'b1  :
                                      ((w1c && mem_dout[gi]) ||
                                       (claim_take && claim_id == ID_W'(gi))) ? 1'b0 :
                                      pending_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
            mask_reg    <= '0;
            edge_reg    <= '1;
            gie_reg     <= 1'b0;
            ir_reg      <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            ir_reg      <= gie_reg & any_active;
            if (wr) begin
                case (offset)
                    INTR_MASK: mask_reg <= mem_dout[N_IRQ-1:0];
                    INTR_CTRL: gie_reg  <= mem_dout[0];
                    INTR_EDGE: edge_reg <= mem_dout[N_IRQ-1:0];
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (offset)
                INTR_PENDING: rdata = {{(32-N_IRQ){1'b0}}, pending_reg};
                INTR_MASK:    rdata = {{(32-N_IRQ){1'b0}}, mask_reg};
                INTR_CTRL:    rdata = {31'b0, gie_reg};
                INTR_CLAIM:   rdata = any_active ? (CLAIM_VALID | {27'b0, claim_id}) : 32'b0;
                INTR_EDGE:    rdata = {{(32-N_IRQ){1'b0}}, edge_reg};
                default:      rdata = '0;
            endcase
        end
    end

    assign ir_out = ir_reg;

    logic unused_bits;
    assign unused_bits = ^{mem_addr[1:0], mem_dout[31:N_IRQ]};

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed and randomized bench for intr_ctrl against a cycle-level
// behavioural model built from sample history and the register rules.
module tb_intr_ctrl;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [N-1:0] irq_src = '0;
    logic        mem_ren = 1'b0;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_dout = '0;
    logic        sel;
    logic [31:0] rdata;
    logic        ir_out;

    int checks = 0;
    int errors = 0;

    // Model state: registers plus the last three sampled input vectors.
    logic [N-1:0] m_pend, m_mask, m_edge;
    logic         m_gie, m_ir;
    logic [N-1:0] h1, h2, h3;

    logic [31:0] got;

    intr_ctrl #(.N_IRQ(N), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_src  (irq_src),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .sel      (sel),
        .rdata    (rdata),
        .ir_out   (ir_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_edge = '1; m_gie = 1'b0; m_ir = 1'b0;
        h1 = '0; h2 = '0; h3 = '0;
    endtask

    function automatic int first_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] addr);
        logic [N-1:0] act;
        int id;
        act = m_pend & m_mask;
        id  = first_set(act);
        if (addr[31:5] != BASE[31:5]) return 32'h0;
        case (addr[4:2])
            3'd0: return 32'(m_pend);
            3'd1: return 32'(m_mask);
            3'd2: return {31'b0, m_gie};
            3'd3: return (id < 0) ? 32'h0 : (32'h8000_0000 + 32'(id));
            3'd4: return 32'(m_edge);
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model across one clock edge, given the bus cycle just ended.
    task automatic model_edge(input logic ren, input logic wen,
                              input logic [31:0] addr, input logic [31:0] dout);
        logic [N-1:0] act, np;
        logic hit, claim;
        int id;
        act   = m_pend & m_mask;
        id    = first_set(act);
        hit   = (addr[31:5] == BASE[31:5]);
        claim = ren && hit && addr[4:2] == 3'd3 && !wen && id >= 0;
        for (int i = 0; i < N; i++) begin
            if (!m_edge[i])                np[i] = h2[i];
            else if (h2[i] && !h3[i])      np[i] = 1'b1;
            else if ((wen && hit && addr[4:2] == 3'd0 && dout[i]) || (claim && id == i))
                                           np[i] = 1'b0;
            else                           np[i] = m_pend[i];
        end
        m_ir = m_gie && (act != 0);
        if (wen && hit) begin
            case (addr[4:2])
                3'd1: m_mask = dout[N-1:0];
                3'd2: m_gie  = dout[0];
                3'd4: m_edge = dout[N-1:0];
                default: ;
            endcase
        end
        m_pend = np;
        h3 = h2; h2 = h1; h1 = irq_src;
    endtask

    // One bus cycle; called at posedge+1, returns at the next posedge+1.
    task automatic bus(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] dout, output logic [31:0] rd);
        logic [31:0] exp_rd;
        mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = dout;
        #1;
        exp_rd = model_rdata(addr);
        rd = rdata;
        chk("sel", {31'b0, sel}, {31'b0, addr[31:5] == BASE[31:5]});
        chk("rdata", rdata, exp_rd);
        @(posedge clk);
        model_edge(ren, wen, addr, dout);
        #1;
        chk("ir_out", {31'b0, ir_out}, {31'b0, m_ir});
        mem_ren = 1'b0; mem_wen = 1'b0;
    endtask

    task automatic idle();
        logic [31:0] d;
        bus(1'b0, 1'b0, 32'h0000_1000, 32'h0, d);
    endtask

    task automatic rd_reg(input logic [2:0] off, output logic [31:0] d);
        bus(1'b1, 1'b0, BASE | {27'b0, off, 2'b00}, 32'h0, d);
    endtask

    task automatic wr_reg(input logic [2:0] off, input logic [31:0] v);
        logic [31:0] d;
        bus(1'b0, 1'b1, BASE | {27'b0, off, 2'b00}, v, d);
    endtask

    task automatic check_reset_values(input string tag);
        rd_reg(3'd0, got); chk({tag, "_pending"}, got, 32'h0);
        rd_reg(3'd1, got); chk({tag, "_mask"},    got, 32'h0);
        rd_reg(3'd2, got); chk({tag, "_ctrl"},    got, 32'h0);
        rd_reg(3'd3, got); chk({tag, "_claim"},   got, 32'h0);
        rd_reg(3'd4, got); chk({tag, "_edge"},    got, 32'hFF);
        rd_reg(3'd6, got); chk({tag, "_unused"},  got, 32'h0);
        chk({tag, "_ir"}, {31'b0, ir_out}, 32'h0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_values("reset");

        // Single pulse on source 3, latency to ir_out, then claim.
        wr_reg(3'd1, 32'h0C);
        wr_reg(3'd2, 32'h1);
        irq_src = 8'h08; idle();
        irq_src = 8'h00; idle();
        idle();
        chk("lat_k2_ir", {31'b0, ir_out}, 32'h0);
        idle();
        chk("lat_k3_ir", {31'b0, ir_out}, 32'h1);
        rd_reg(3'd3, got); chk("claim3", got, 32'h8000_0003);
        idle();
        chk("ir_after_claim", {31'b0, ir_out}, 32'h0);

        // Two simultaneous sources claimed in priority order.
        wr_reg(3'd1, 32'h24);
        irq_src = 8'h24; idle();
        irq_src = 8'h00; idle(); idle(); idle();
        rd_reg(3'd3, got); chk("claim_first",  got, 32'h8000_0002);
        rd_reg(3'd3, got); chk("claim_second", got, 32'h8000_0005);
        rd_reg(3'd3, got); chk("claim_third",  got, 32'h0);

        // W1C coinciding with a fresh rise on source 1: set wins.
        irq_src = 8'h02; idle();
        irq_src = 8'h00; idle(); idle();
        irq_src = 8'h02; idle();
        irq_src = 8'h00; idle();
        wr_reg(3'd0, 32'h2);
        rd_reg(3'd0, got); chk("set_wins", got & 32'h2, 32'h2);
        wr_reg(3'd0, 32'h2);
        rd_reg(3'd0, got); chk("w1c_clears", got & 32'h2, 32'h0);

        // Level mode: W1C and claim have no effect; input drop clears.
        wr_reg(3'd4, 32'h00);
        wr_reg(3'd1, 32'h01);
        irq_src = 8'h01; idle(); idle(); idle();
        rd_reg(3'd0, got); chk("lvl_set", got & 32'h1, 32'h1);
        wr_reg(3'd0, 32'h1);
        rd_reg(3'd0, got); chk("lvl_w1c", got & 32'h1, 32'h1);
        rd_reg(3'd3, got); chk("lvl_claim", got, 32'h8000_0000);
        rd_reg(3'd0, got); chk("lvl_after_claim", got & 32'h1, 32'h1);
        irq_src = 8'h00; idle(); idle(); idle();
        rd_reg(3'd0, got); chk("lvl_drop", got & 32'h1, 32'h0);

        // Randomized traffic, including ren+wen together and misses.
        wr_reg(3'd2, 32'h1);
        for (int n = 0; n < 600; n++) begin
            logic        r, w;
            logic [31:0] a, d;
            if ($urandom_range(0, 3) == 0) irq_src = N'($urandom);
            r = ($urandom_range(0, 2) != 0);
            w = ($urandom_range(0, 4) == 0);
            d = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                a = BASE | {27'b0, 3'($urandom_range(0, 7)), 2'($urandom)};
                if ($urandom_range(0, 2) == 0) a[4:2] = 3'd3;
            end else begin
                a = $urandom;
            end
            bus(r, w, a, d, got);
        end

        // Asynchronous reset while a request is active.
        irq_src = 8'h00;
        wr_reg(3'd4, 32'hFF);
        wr_reg(3'd1, 32'hFF);
        wr_reg(3'd2, 32'h1);
        irq_src = 8'h10; idle();
        irq_src = 8'h00; idle(); idle(); idle();
        chk("pre_rst_ir", {31'b0, ir_out}, 32'h1);
        #2 rst = 1'b1;
        #1 chk("async_rst_ir", {31'b0, ir_out}, 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset_values("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
